calc_g_coord_sqsum: RTL
=======================

// Module: calc_g_coord_sqsum
// PURPOSE
//  Raster-scans an H_RES x V_RES pixel grid for one object point (obj_x, obj_y).
//  Emits per pixel r2 = (x-obj_x)^2 + (y-obj_y)^2 as an unsigned 20-bit value.
//  Sits directly upstream of the 32x20 zparam multiplier, whose 20-bit operand it
//  feeds; the multiplier's low 12 bits become the pixel phase (theta).
// PARAMETERS
//  H_RES   512  pixels per row; power of two, <= 512
//  V_RES   512  rows per frame; power of two, <= 512
//  CW      9    coordinate width = log2(max(H_RES,V_RES))
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   1-cycle pulse: begin a frame scan (ignored while busy)
//  obj_x       in   CW  object point column, sampled on accepted start
//  obj_y       in   CW  object point row, sampled on accepted start
//  busy        out  1   high from accepted start until done pulse, inclusive
//  done        out  1   1-cycle pulse after last pixel handshakes out
//  out_valid   out  1   out_* holds a valid pixel result
//  out_ready   in   1   downstream accepts when out_valid && out_ready
//  out_x       out  CW  pixel column of result
//  out_y       out  CW  pixel row of result
//  out_r2      out  20  (x-obj_x)^2 + (y-obj_y)^2, unsigned
// BEHAVIOUR
//  - Reset: busy=0, done=0, out_valid=0, out_x=0, out_y=0, out_r2=0; FSM->IDLE;
//    reset mid-scan aborts the frame, no done pulse, in-flight pipeline flushed.
//  - FSM: IDLE --start--> SCAN --last pixel issued--> DRAIN --pipe empty &
//    last handshake--> DONE (1 cycle, done=1) --> IDLE.
//  - Scan order x fastest: (0,0),(1,0)..(H_RES-1,0),(0,1)..(H_RES-1,V_RES-1).
//    x wraps to 0 and y increments on same cycle; issue stops after final pixel.
//  - Arithmetic: dx,dy = signed CW+1-bit differences; squares unsigned 2*CW bits;
//    r2 zero-extended to 20; max 2*511^2=522242 < 2^20, never overflows.
//  - Pipeline: 3 stages (diff, square, sum); first out_valid exactly 3 cycles
//    after accepted start with out_ready held 1; then one result per cycle.
//  - Backpressure: out_valid && !out_ready stalls whole pipe and scan counters;
//    out_* held stable while stalled; out_valid never drops without handshake.
//  - Exactly H_RES*V_RES handshakes per frame, no bubbles while out_ready=1.
//  - start while busy: ignored, obj_x/obj_y not resampled.
//  - start in DONE cycle: ignored; accepted only in IDLE.
// CONFIGURATION
//  CALC_G_EOL_EN defined: extra port out_eol (out, 1) high with out_valid on the
//    last pixel of every row (out_x==H_RES-1), follows same stall rules; reset 0.
//  CALC_G_EOL_EN undefined: port absent, no row-end logic.
// STRUCTURE
//  Shared package calc_g_pkg: CW, R2_W=20, H_RES/V_RES defaults, FSM state
//    encodings (IDLE, SCAN, DRAIN, DONE).
//  Sub-module calc_g_sqsum_pipe: 3-stage diff/square/sum datapath with common
//    enable and valid bits; top holds FSM, scan counters, handshake.
// TESTING
//  1 rst, obj=(0,0), start, out_ready=1 -> first out (0,0,r2=0) at cycle 3;
//    pixel (511,511) r2=522242; done 1 cycle after 262144th handshake.
//  2 obj=(256,100): pixel (250,103) -> r2=45; (256,100) -> r2=0.
//  3 out_ready random 50% -> sequence identical to test 1, out_* stable while
//    stalled, exactly 262144 handshakes.
//  4 start pulsed mid-scan with obj=(5,5) -> ignored; results still for obj (0,0).
//  5 rst after 1000 handshakes -> next cycle all outputs 0, no done; new start
//    restarts at (0,0).
//  6 CALC_G_EOL_EN, H_RES=V_RES=8 -> out_eol on x=7 only, 8 pulses per frame.

Source files
------------

// File: rtl/calc_g_pkg.sv
// Shared types and constants for the object-point r2 raster generator.
package calc_g_pkg;

  localparam int unsigned CW        = 9;
  localparam int unsigned R2_W      = 20;
  localparam int unsigned SQ_W      = 2 * CW;
  localparam int unsigned H_RES_DEF = 512;
  localparam int unsigned V_RES_DEF = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  // Square of a signed CW+1-bit difference; |d| <= 2^CW-1 so the magnitude fits CW bits.
  function automatic logic [SQ_W-1:0] sq_mag(input logic signed [CW:0] d);
    logic [CW-1:0] mag;
    mag = d[CW] ? CW'(-d) : d[CW-1:0];
    return SQ_W'(mag) * SQ_W'(mag);
  endfunction

endpackage

// File: rtl/calc_g_sqsum_pipe.sv
// Three-stage diff/square/sum datapath with one shared enable for backpressure.
// Row-end flag tracking is present only when CALC_G_EOL_EN is defined.
module calc_g_sqsum_pipe
  import calc_g_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            in_valid_i,
  input  logic [CW-1:0]   in_x_i,
  input  logic [CW-1:0]   in_y_i,
  input  logic [CW-1:0]   obj_x_i,
  input  logic [CW-1:0]   obj_y_i,
`ifdef CALC_G_EOL_EN
  input  logic            in_eol_i,
  output logic            out_eol_o,
`endif
  output logic            s1_valid_o,
  output logic            s2_valid_o,
  output logic            out_valid_o,
  output logic [CW-1:0]   out_x_o,
  output logic [CW-1:0]   out_y_o,
  output logic [R2_W-1:0] out_r2_o
);

  logic               s1_v_q, s2_v_q, s3_v_q;
  pix_t               s1_pix_q, s2_pix_q, s3_pix_q;
  logic signed [CW:0] dx_d, dy_d, dx_q, dy_q;
  logic [SQ_W-1:0]    sqx_q, sqy_q;
  logic [R2_W-1:0]    r2_q;

  always_comb begin
    dx_d = $signed({1'b0, in_x_i}) - $signed({1'b0, obj_x_i});
    dy_d = $signed({1'b0, in_y_i}) - $signed({1'b0, obj_y_i});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      s1_pix_q <= '0;
      s2_pix_q <= '0;
      s3_pix_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sqx_q    <= '0;
      sqy_q    <= '0;
      r2_q     <= '0;
    end else if (en_i) begin
      s1_v_q   <= in_valid_i;
      s1_pix_q <= '{x: in_x_i, y: in_y_i};
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      s2_v_q   <= s1_v_q;
      s2_pix_q <= s1_pix_q;
      sqx_q    <= sq_mag(dx_q);
      sqy_q    <= sq_mag(dy_q);
      s3_v_q   <= s2_v_q;
      s3_pix_q <= s2_pix_q;
      r2_q     <= R2_W'(sqx_q) + R2_W'(sqy_q);
    end
  end

`ifdef CALC_G_EOL_EN
  logic eol1_q, eol2_q, eol3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eol1_q <= 1'b0;
      eol2_q <= 1'b0;
      eol3_q <= 1'b0;
    end else if (en_i) begin
      eol1_q <= in_valid_i & in_eol_i;
      eol2_q <= eol1_q;
      eol3_q <= eol2_q;
    end
  end

  assign out_eol_o = eol3_q;
`endif

  assign s1_valid_o  = s1_v_q;
  assign s2_valid_o  = s2_v_q;
  assign out_valid_o = s3_v_q;
  assign out_x_o     = s3_pix_q.x;
  assign out_y_o     = s3_pix_q.y;
  assign out_r2_o    = r2_q;

endmodule

// File: rtl/calc_g_coord_sqsum.sv
// Frame FSM, raster counters and output handshake around the r2 datapath.
// Optional row-end output out_eol_o is enabled by defining CALC_G_EOL_EN.
module calc_g_coord_sqsum
  import calc_g_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [CW-1:0]   obj_x_i,
  input  logic [CW-1:0]   obj_y_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [CW-1:0]   out_x_o,
  output logic [CW-1:0]   out_y_o,
`ifdef CALC_G_EOL_EN
  output logic            out_eol_o,
`endif
  output logic [R2_W-1:0] out_r2_o
);

  localparam logic [CW-1:0] XMAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] YMAX = CW'(V_RES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          en_c, issue_c, last_pix_c, pipe_empty_c;
  logic          s1_v, s2_v, out_valid_w;

  // Whole pipe and scan advance together unless a held result is refused.
  assign en_c         = ~out_valid_w | out_ready_i;
  assign issue_c      = (state_q == ST_SCAN) & en_c;
  assign last_pix_c   = (x_q == XMAX) & (y_q == YMAX);
  assign pipe_empty_c = ~s1_v & ~s2_v;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      obj_x_q <= '0;
      obj_y_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      obj_x_q <= obj_x_d;
      obj_y_q <= obj_y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SCAN;
      ST_SCAN:  if (issue_c && last_pix_c) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty_c && out_valid_w && out_ready_i) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    obj_x_d = obj_x_q;
    obj_y_d = obj_y_q;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    if (state_q == ST_IDLE && start_i) begin
      x_d     = '0;
      y_d     = '0;
      obj_x_d = obj_x_i;
      obj_y_d = obj_y_i;
    end else if (issue_c) begin
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  calc_g_sqsum_pipe u_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_c),
    .in_valid_i  (issue_c),
    .in_x_i      (x_q),
    .in_y_i      (y_q),
    .obj_x_i     (obj_x_q),
    .obj_y_i     (obj_y_q),
`ifdef CALC_G_EOL_EN
    .in_eol_i    (x_q == XMAX),
    .out_eol_o   (out_eol_o),
`endif
    .s1_valid_o  (s1_v),
    .s2_valid_o  (s2_v),
    .out_valid_o (out_valid_w),
    .out_x_o     (out_x_o),
    .out_y_o     (out_y_o),
    .out_r2_o    (out_r2_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign out_valid_o = out_valid_w;

endmodule
